// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel
//   N-channel PWM generator sharing one prescaled timebase. Period, duties, counting
//   mode and prescale are double-buffered: a load strobe stages new values, and the
//   staged set becomes active only at a period boundary (or at once while disabled),
//   so outputs never glitch mid-period.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   enable      1 = run timebase, 0 = halt with outputs low
//   load        1-cycle strobe: stage period/duty/mode/prescale
//   period      staged top count
//   duty        staged duties, channel i = duty[i*R_BITS +: R_BITS]
//   mode        staged mode: 0 edge-aligned, 1 center-aligned
//   prescale    staged prescale: one tick every prescale+1 clocks
//   pending     staged values waiting for a boundary
//   period_end  1-clk pulse, registered from the boundary tick
//   pwm_out     registered PWM outputs
module pwm_multi_channel #(
    parameter int unsigned R_BITS     = 8,
    parameter int unsigned N_CH       = 4,
    parameter int unsigned PRESC_BITS = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     load,
    input  logic [R_BITS-1:0]        period,
    input  logic [N_CH*R_BITS-1:0]   duty,
    input  logic                     mode,
    input  logic [PRESC_BITS-1:0]    prescale,
    output logic                     pending,
    output logic                     period_end,
    output logic [N_CH-1:0]          pwm_out
);

    typedef enum logic {DirUp, DirDown} dir_e;

    // Active and staged configuration
    logic [R_BITS-1:0]      period_act_q, period_stg_q;
    logic [N_CH*R_BITS-1:0] duty_act_q, duty_stg_q;
    logic                   mode_act_q, mode_stg_q;
    logic [PRESC_BITS-1:0]  prescale_act_q, prescale_stg_q;

    // Timebase state
    logic [PRESC_BITS-1:0]  presc_cnt_q, presc_cnt_d;
    logic [R_BITS-1:0]      cnt_q, cnt_d;
    dir_e                   dir_q, dir_d;
    logic                   pending_q, pending_d;
    logic                   period_end_q;
    logic [N_CH-1:0]        pwm_q, pwm_d;

    logic tick, center_ud, last, boundary, apply;

    always_comb begin
        tick      = enable && (presc_cnt_q == prescale_act_q);
        // Up/down counting only makes a difference for period >= 2; center mode with
        // period 1 yields the same 0,1 sequence as edge mode, and period 0 is edge mode.
        center_ud = mode_act_q && (period_act_q > R_BITS'(1));
        // Center cycle is 0,1..P,P-1..1 (2*P ticks, symmetric about P); the tick that
        // would bring the down-count back to 0 is the boundary, and the boundary itself
        // reloads cnt=0 with dir=up.
        if (center_ud) begin
            last = (dir_q == DirDown) && (cnt_q == R_BITS'(1));
        end else begin
            last = (cnt_q == period_act_q);
        end
        boundary = tick && last;
        // While disabled there is no period in flight, so staged values go live at once.
        apply    = pending_q && (boundary || !enable);

        presc_cnt_d = presc_cnt_q;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        if (!enable) begin
            presc_cnt_d = '0;
            cnt_d       = '0;
            dir_d       = DirUp;
        end else if (tick) begin
            presc_cnt_d = '0;
            if (boundary) begin
                cnt_d = '0;
                dir_d = DirUp;
            end else if (center_ud && (dir_q == DirDown)) begin
                cnt_d = cnt_q - R_BITS'(1);
            end else if (center_ud && (cnt_q == period_act_q)) begin
                cnt_d = cnt_q - R_BITS'(1);
                dir_d = DirDown;
            end else begin
                cnt_d = cnt_q + R_BITS'(1);
            end
        end else begin
            presc_cnt_d = presc_cnt_q + PRESC_BITS'(1);
        end
        if (apply) begin
            presc_cnt_d = '0;
        end

        // A load coinciding with an apply is kept pending for the following boundary.
        if (load) begin
            pending_d = 1'b1;
        end else if (apply) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end

        pwm_d = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            pwm_d[i] = enable && (cnt_q < duty_act_q[i*R_BITS +: R_BITS]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_act_q   <= '0;
            period_stg_q   <= '0;
            duty_act_q     <= '0;
            duty_stg_q     <= '0;
            mode_act_q     <= 1'b0;
            mode_stg_q     <= 1'b0;
            prescale_act_q <= '0;
            prescale_stg_q <= '0;
            presc_cnt_q    <= '0;
            cnt_q          <= '0;
            dir_q          <= DirUp;
            pending_q      <= 1'b0;
            period_end_q   <= 1'b0;
            pwm_q          <= '0;
        end else begin
            presc_cnt_q  <= presc_cnt_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            pending_q    <= pending_d;
            period_end_q <= boundary;
            pwm_q        <= pwm_d;
            // Apply reads the staged set from before this cycle's load.
            if (apply) begin
                period_act_q   <= period_stg_q;
                duty_act_q     <= duty_stg_q;
                mode_act_q     <= mode_stg_q;
                prescale_act_q <= prescale_stg_q;
            end
            if (load) begin
                period_stg_q   <= period;
                duty_stg_q     <= duty;
                mode_stg_q     <= mode;
                prescale_stg_q <= prescale;
            end
        end
    end

    assign pending    = pending_q;
    assign period_end = period_end_q;
    assign pwm_out    = pwm_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
module tb_pwm_multi_channel;

    localparam int R  = 8;
    localparam int N  = 4;
    localparam int PB = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             enable = 1'b0;
    logic             load = 1'b0;
    logic [R-1:0]     period = '0;
    logic [N*R-1:0]   duty = '0;
    logic             mode = 1'b0;
    logic [PB-1:0]    prescale = '0;
    logic             pending;
    logic             period_end;
    logic [N-1:0]     pwm_out;

    pwm_multi_channel #(.R_BITS(R), .N_CH(N), .PRESC_BITS(PB)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .period     (period),
        .duty       (duty),
        .mode       (mode),
        .prescale   (prescale),
        .pending    (pending),
        .period_end (period_end),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] pwm;
        logic         pe;
        logic         pend;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position within the current period (in ticks) plus the
    // configuration sets; the count is derived from position arithmetically.
    int           s_per, s_mode, s_pr;
    int           s_duty[N];
    int           a_per, a_mode, a_pr;
    int           a_duty[N];
    int           m_presc, m_pos;
    logic         m_pend;
    logic [N-1:0] m_pwm;
    logic         m_pe;

    task automatic model_step();
        int   p, len, c;
        logic tk, bnd, apl;
        exp_t e;
        if (reset) begin
            s_per = 0; s_mode = 0; s_pr = 0;
            a_per = 0; a_mode = 0; a_pr = 0;
            for (int i = 0; i < N; i++) begin
                s_duty[i] = 0;
                a_duty[i] = 0;
            end
            m_presc = 0; m_pos = 0; m_pend = 1'b0; m_pwm = '0; m_pe = 1'b0;
        end else begin
            p   = a_per;
            len = (a_mode != 0 && p > 0) ? 2 * p : p + 1;
            c   = (m_pos <= p) ? m_pos : 2 * p - m_pos;
            tk  = enable && (m_presc == a_pr);
            bnd = tk && (m_pos == len - 1);
            for (int i = 0; i < N; i++) m_pwm[i] = enable && (c < a_duty[i]);
            m_pe = bnd;
            apl  = m_pend && (bnd || !enable);
            if (!enable) begin
                m_presc = 0; m_pos = 0;
            end else if (tk) begin
                m_presc = 0;
                m_pos   = bnd ? 0 : m_pos + 1;
            end else begin
                m_presc++;
            end
            if (apl) begin
                a_per = s_per; a_mode = s_mode; a_pr = s_pr;
                for (int i = 0; i < N; i++) a_duty[i] = s_duty[i];
                m_presc = 0;
            end
            if (load) begin
                s_per = int'(period); s_mode = int'(mode); s_pr = int'(prescale);
                for (int i = 0; i < N; i++) s_duty[i] = int'(duty[i*R +: R]);
                m_pend = 1'b1;
            end else if (apl) begin
                m_pend = 1'b0;
            end
        end
        e.pwm = m_pwm; e.pe = m_pe; e.pend = m_pend;
        exp_q.push_back(e);
    endtask

    // Inputs change on the falling edge; the model predicts the next rising edge.
    task automatic cyc(input logic r, input logic en, input logic ld);
        reset  = r;
        enable = en;
        load   = ld;
        model_step();
        @(negedge clk);
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic set_cfg(input int per, input int md, input int pr,
                           input int d0, input int d1, input int d2, input int d3);
        period   = R'(per);
        mode     = md[0];
        prescale = PB'(pr);
        duty[0*R +: R] = R'(d0);
        duty[1*R +: R] = R'(d1);
        duty[2*R +: R] = R'(d2);
        duty[3*R +: R] = R'(d3);
    endtask

    task automatic rand_cfg();
        int per;
        per      = int'($urandom_range(0, 12));
        period   = R'(per);
        mode     = $urandom_range(0, 1) == 1;
        prescale = PB'($urandom_range(0, 3));
        for (int i = 0; i < N; i++) duty[i*R +: R] = R'($urandom_range(0, per + 2));
    endtask

    // Monitor: every rising edge presents one registered result.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (pwm_out !== e.pwm) begin
                    n_bad++;
                    $display("FAIL pwm_out @%0t: got %b want %b", $time, pwm_out, e.pwm);
                end
                n_cmp++;
                if (period_end !== e.pe) begin
                    n_bad++;
                    $display("FAIL period_end @%0t: got %b want %b", $time, period_end, e.pe);
                end
                n_cmp++;
                if (pending !== e.pend) begin
                    n_bad++;
                    $display("FAIL pending @%0t: got %b want %b", $time, pending, e.pend);
                end
            end
        end
    end

    initial begin
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);

        // Edge, period 9, duty0 3; loaded while disabled so it applies next clock
        set_cfg(9, 0, 0, 3, 0, 10, 9);
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0);
        run(35);

        // Constant-0 / constant-1 channels
        set_cfg(9, 0, 0, 0, 10, 5, 200);
        cyc(1'b0, 1'b1, 1'b1);
        run(30);

        // Center, period 4, duty0 2
        set_cfg(4, 1, 0, 2, 5, 4, 0);
        cyc(1'b0, 1'b1, 1'b1);
        run(30);

        // Prescale 3, period 4, edge
        set_cfg(4, 0, 3, 2, 1, 5, 3);
        cyc(1'b0, 1'b1, 1'b1);
        run(60);

        // Back-to-back loads mid-period: last load wins at the boundary
        set_cfg(9, 0, 0, 2, 2, 2, 2);
        cyc(1'b0, 1'b1, 1'b1);
        run(14);
        set_cfg(9, 0, 0, 5, 2, 2, 2);
        cyc(1'b0, 1'b1, 1'b1);
        run(2);
        set_cfg(9, 0, 0, 7, 2, 2, 2);
        cyc(1'b0, 1'b1, 1'b1);
        run(25);

        // Reset mid-period takes effect without waiting for a clock
        run(4);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (pwm_out !== '0 || pending !== 1'b0 || period_end !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: got pwm=%b pend=%b pe=%b want 0/0/0",
                     pwm_out, pending, period_end);
        end
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0);
        set_cfg(6, 0, 0, 3, 1, 0, 7);
        cyc(1'b0, 1'b0, 1'b1);
        run(20);
        // Drop enable, then restart
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0);
        run(20);

        // Randomized traffic
        for (int r = 0; r < 30; r++) begin
            int n;
            logic en;
            en = 1'b1;
            rand_cfg();
            cyc(1'b0, en, 1'b1);
            n = int'($urandom_range(20, 120));
            for (int k = 0; k < n; k++) begin
                int u;
                logic rs, ld;
                u  = int'($urandom_range(0, 999));
                rs = (u < 5);
                ld = 1'b0;
                if (u >= 5 && u < 40) begin
                    rand_cfg();
                    ld = 1'b1;
                end else if (u >= 40 && u < 60) begin
                    en = ~en;
                end
                cyc(rs, en, ld);
            end
        end

        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d unchecked results want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
